// File: rtl/twiddle_rotator_if.sv
// twiddle_rotator_if: streaming sample-in / result-out bundle for the twiddle
// rotator. The slave modport is the rotator's view; master is the view of the
// address sequencer and butterfly stage around it.
interface twiddle_rotator_if #(
  parameter int TAG_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic        [2:0]       in_stage;
  logic        [6:0]       in_index;
  logic                    in_inverse;
  logic signed [15:0]      in_br;
  logic signed [15:0]      in_bi;
  logic        [TAG_W-1:0] in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [15:0]      out_re;
  logic signed [15:0]      out_im;
  logic        [TAG_W-1:0] out_tag;
  logic                    out_sat;

  modport slave (
    input  in_valid, in_stage, in_index, in_inverse, in_br, in_bi, in_tag, out_ready,
    output in_ready, out_valid, out_re, out_im, out_tag, out_sat
  );

  modport master (
    output in_valid, in_stage, in_index, in_inverse, in_br, in_bi, in_tag, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_tag, out_sat
  );
endinterface

// File: rtl/twiddle_rotator.sv
// twiddle_rotator: multiplies a butterfly lower-leg sample B by W_256^k (or by
// conj(W) for the inverse transform), rounds half-up back to Q15 and streams the
// result through a 3-stage valid/ready pipeline at one sample per clock.
// Build option: define TWIDDLE_ROTATOR_SAT_EN to clip out-of-range results and
// flag them on out_sat; otherwise results wrap and out_sat stays 0.
module twiddle_rotator #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  twiddle_rotator_if.slave bus
);

  // Quarter-wave sine, QSIN[m] = round(32767*sin(2*pi*m/256)), m = 0..64.
  // The full 128-entry cos/-sin table is folded onto this by symmetry.
  localparam logic signed [15:0] QSIN [0:64] = '{
    16'sd0,     16'sd804,   16'sd1608,  16'sd2410,  16'sd3212,  16'sd4011,  16'sd4808,  16'sd5602,
    16'sd6393,  16'sd7179,  16'sd7962,  16'sd8739,  16'sd9512,  16'sd10278, 16'sd11039, 16'sd11793,
    16'sd12539, 16'sd13279, 16'sd14010, 16'sd14732, 16'sd15446, 16'sd16151, 16'sd16846, 16'sd17530,
    16'sd18204, 16'sd18868, 16'sd19519, 16'sd20159, 16'sd20787, 16'sd21403, 16'sd22005, 16'sd22594,
    16'sd23170, 16'sd23731, 16'sd24279, 16'sd24811, 16'sd25329, 16'sd25832, 16'sd26319, 16'sd26790,
    16'sd27245, 16'sd27683, 16'sd28105, 16'sd28510, 16'sd28898, 16'sd29268, 16'sd29621, 16'sd29956,
    16'sd30273, 16'sd30571, 16'sd30852, 16'sd31113, 16'sd31356, 16'sd31580, 16'sd31785, 16'sd31971,
    16'sd32137, 16'sd32285, 16'sd32412, 16'sd32521, 16'sd32609, 16'sd32678, 16'sd32728, 16'sd32757,
    16'sd32767
  };

  // k = (j mod 2^s) << (7 - s); the mask keeps the low s bits of j.
  function automatic logic [6:0] twiddle_addr(input logic [2:0] s, input logic [6:0] j);
    logic [6:0] mask;
    mask = 7'h7f >> (3'd7 - s);
    return (j & mask) << (3'd7 - s);
  endfunction

  // Returns {wr, wi} = {cos, -sin} of 2*pi*k/256. For k > 64 the angle is in the
  // second quadrant: cos goes negative and sin mirrors about k = 64.
  function automatic logic [31:0] twiddle_lut(input logic [6:0] k);
    logic signed [15:0] wr;
    logic signed [15:0] wi;
    if (k <= 7'd64) begin
      wr = QSIN[7'd64 - k];
      wi = -QSIN[k];
    end else begin
      wr = -QSIN[k - 7'd64];
      wi = -QSIN[7'd0 - k];
    end
    return {wr, wi};
  endfunction

  // Round half-up to Q15; returns {clipped, value}.
  function automatic logic [16:0] round_sat(input logic signed [32:0] acc);
`ifdef TWIDDLE_ROTATOR_SAT_EN
    logic signed [32:0] r;
    r = (acc + 33'sd16384) >>> 15;
    if (r > 33'sd32767)       return {1'b1, 16'h7fff};
    else if (r < -33'sd32768) return {1'b1, 16'h8000};
    else                      return {1'b0, r[15:0]};
`else
    return {1'b0, 16'((acc + 33'sd16384) >>> 15)};
`endif
  endfunction

  logic                    stall;
  logic                    adv;
  logic                    vld_p1_q, vld_p2_q, vld_p3_q;
  logic signed [15:0]      wr_p1_q, wi_p1_q, br_p1_q, bi_p1_q;
  logic        [TAG_W-1:0] tag_p1_q, tag_p2_q, tag_p3_q;
  logic signed [31:0]      prr_p2_q, pii_p2_q, pri_p2_q, pir_p2_q;
  logic signed [15:0]      re_p3_q, im_p3_q;
  logic                    sat_p3_q;

  logic        [6:0]       k_d;
  logic        [31:0]      w_d;
  logic signed [15:0]      wr_d, wi_d;
  logic signed [32:0]      acc_re, acc_im;
  logic        [16:0]      res_re, res_im;
  logic signed [15:0]      re_d, im_d;
  logic                    sat_d;

  // A held result freezes the whole pipeline, bubbles included.
  assign stall        = vld_p3_q & ~bus.out_ready;
  assign adv          = ~stall;
  assign bus.in_ready = adv;

  // Stage 0 -> P1: address, table lookup, conjugate for inverse mode.
  always_comb begin
    k_d  = twiddle_addr(bus.in_stage, bus.in_index);
    w_d  = twiddle_lut(k_d);
    wr_d = w_d[31:16];
    wi_d = bus.in_inverse ? -$signed(w_d[15:0]) : $signed(w_d[15:0]);
  end

  // Valid bits advance together and clear on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else if (adv) begin
      vld_p1_q <= bus.in_valid;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
    end
  end

  // P1 and P2 data registers; P1 -> P2 forms the four partial products.
  always_ff @(posedge clk) begin
    if (adv) begin
      wr_p1_q  <= wr_d;
      wi_p1_q  <= wi_d;
      br_p1_q  <= bus.in_br;
      bi_p1_q  <= bus.in_bi;
      tag_p1_q <= bus.in_tag;
      prr_p2_q <= br_p1_q * wr_p1_q;
      pii_p2_q <= bi_p1_q * wi_p1_q;
      pri_p2_q <= br_p1_q * wi_p1_q;
      pir_p2_q <= bi_p1_q * wr_p1_q;
      tag_p2_q <= tag_p1_q;
    end
  end

  // P2 -> P3: complex sums in 33 bits, then round and clip/wrap.
  always_comb begin
    acc_re = 33'(prr_p2_q) - 33'(pii_p2_q);
    acc_im = 33'(pri_p2_q) + 33'(pir_p2_q);
    res_re = round_sat(acc_re);
    res_im = round_sat(acc_im);
    re_d   = res_re[15:0];
    im_d   = res_im[15:0];
    sat_d  = res_re[16] | res_im[16];
  end

  // P3 output registers, cleared on reset so the bus idles at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      re_p3_q  <= '0;
      im_p3_q  <= '0;
      tag_p3_q <= '0;
      sat_p3_q <= 1'b0;
    end else if (adv) begin
      re_p3_q  <= re_d;
      im_p3_q  <= im_d;
      tag_p3_q <= tag_p2_q;
      sat_p3_q <= sat_d;
    end
  end

  assign bus.out_valid = vld_p3_q;
  assign bus.out_re    = re_p3_q;
  assign bus.out_im    = im_p3_q;
  assign bus.out_tag   = tag_p3_q;
  assign bus.out_sat   = sat_p3_q;

endmodule
